// File: rtl/switch_debouncer_pkg.sv
// +--------------------------------------------------------------------+
// | switch_pkg                                                         |
// | Shared defaults and the debounce counter width helper.            |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package switch_pkg;

  localparam int SW_WIDTH_DEF    = 16;
  localparam int SW_SYNC_DEF     = 2;
  localparam int SW_DEBOUNCE_DEF = 100000;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int sw_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debouncer_debounce_bit.sv
// +--------------------------------------------------------------------+
// | debounce_bit                                                       |
// | One switch channel: synchroniser chain, run counter, stable level |
// | and registered rise/fall strobes.                                  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module debounce_bit
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES     = SW_SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_o
);

  localparam int            CW      = sw_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   filt_in;

  assign sync_d  = {sync_q[SYNC_STAGES-2:0], sw_i};
  assign filt_in = sync_q[SYNC_STAGES-1];

  // Counter idles at zero whenever the input agrees with the stable level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (filt_in != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = filt_in;
        rise_d  = filt_in;
        fall_d  = ~filt_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = rise_d | fall_d;

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// +--------------------------------------------------------------------+
// | switch_debouncer                                                   |
// | WIDTH independent synchronised/debounced switch channels with     |
// | edge strobes. Define SWITCH_DEBOUNCER_IRQ_EN for sticky pending   |
// | flags and an IRQ line.                                             |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH_DEF,
  parameter int SYNC_STAGES     = SW_SYNC_DEF,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_O,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL,
  output logic             SW_CHANGED,
  input  logic [WIDTH-1:0] IRQ_CLR,
  output logic [WIDTH-1:0] IRQ_PEND,
  output logic             IRQ
);

  logic [WIDTH-1:0] event_w;
  logic             changed_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk_i  (CLK),
      .rst_i  (RST),
      .sw_i   (SW[i]),
      .level_o(SW_O[i]),
      .rise_o (SW_RISE[i]),
      .fall_o (SW_FALL[i]),
      .event_o(event_w[i])
    );
  end

  // Reduced from next-state strobes so it lands in the same cycle as them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= |event_w;
    end
  end

  assign SW_CHANGED = changed_q;

`ifdef SWITCH_DEBOUNCER_IRQ_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q;

  // A new event outranks a simultaneous clear.
  assign pend_d = (pend_q & ~IRQ_CLR) | SW_RISE | SW_FALL;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      irq_q  <= |pend_d;
    end
  end

  assign IRQ_PEND = pend_q;
  assign IRQ      = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^IRQ_CLR;
  assign IRQ_PEND       = '0;
  assign IRQ            = 1'b0;
`endif

endmodule

`default_nettype wire
